pad_window_ctrl: RTL and testbench
==================================

PAD_WINDOW_CTRL -- requirements
Module: pad_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 10, pixel width per tap.
REQ-002 SHALL have parameter DIM_W, default 8, width of frame dimension fields and counters.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  frame start request, sampled in IDLE only.
REQ-006 SHALL have port i_cfg_width  input  DIM_W  frame width in pixels, latched on accepted start.
REQ-007 SHALL have port i_cfg_height  input  DIM_W  frame height in pixels, latched on accepted start.
REQ-008 SHALL have port i_win_valid  input  1  upstream 3x3 window valid.
REQ-009 SHALL have port o_win_ready  output  1  block can accept a window this cycle.
REQ-010 SHALL have port i_win_data  input  9*DATA_W  window; tap k = 3*r+c at bits [DATA_W*k +: DATA_W]; r=0 top row, c=0 left column.
REQ-011 SHALL have port o_win_valid  output  1  masked window valid downstream.
REQ-012 SHALL have port i_win_ready  input  1  downstream accepts window.
REQ-013 SHALL have port o_win_data  output  9*DATA_W  masked window, same tap layout.
REQ-014 SHALL have port o_tap_mask  output  9  per-tap keep flag (1 = tap passed, 0 = tap zeroed), bit k = tap k.
REQ-015 SHALL have port o_last  output  1  qualifies o_win_valid; window is last of frame.
REQ-016 SHALL have port o_busy  output  1  high in RUN and DONE.
REQ-017 SHALL have port o_done  output  1  single-cycle frame-complete pulse.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE: i_start=1 SHALL latch width/height, clear row/col counters to 0, go to RUN; if either latched dimension is 0, go to DONE instead, no windows accepted.
REQ-020 i_start outside IDLE SHALL be ignored.
REQ-021 o_win_ready SHALL equal (state==RUN) && (!o_win_valid || i_win_ready).
REQ-022 Accept = i_win_valid && o_win_ready; on accept, o_win_data/o_tap_mask/o_last SHALL register next edge, o_win_valid=1 (latency 1 cycle).
REQ-023 Tap k SHALL be zeroed when (r=0 and row=0) or (r=2 and row=H-1) or (c=0 and col=0) or (c=2 and col=W-1); otherwise passed unchanged.
REQ-024 W=1 SHALL zero both left and right columns; H=1 SHALL zero both top and bottom rows.
REQ-025 On accept, col SHALL increment; at col=W-1 col SHALL wrap to 0 and row increment.
REQ-026 Accept at row=H-1, col=W-1 SHALL set o_last for that window and move FSM to DONE.
REQ-027 While o_win_valid=1 and i_win_ready=0, o_win_data, o_tap_mask, o_last SHALL hold stable.
REQ-028 o_win_valid SHALL clear on downstream transfer without simultaneous accept.
REQ-029 Simultaneous downstream transfer and upstream accept SHALL sustain 1 window/cycle.
REQ-030 DONE: when o_win_valid=0, or its last window transfers this cycle, SHALL assert o_done next cycle for exactly 1 cycle and return to IDLE.
REQ-031 Zero-dimension frame SHALL pulse o_done the cycle after entering DONE.

Reset
REQ-032 i_rst_n=0 at a rising edge SHALL force IDLE, row=col=0, latched dimensions 0, o_win_valid=0, o_win_data=0, o_tap_mask=0, o_last=0, o_done=0; o_busy=0, o_win_ready=0.
REQ-033 Reset mid-frame SHALL discard in-flight window; next frame SHALL start at row 0, col 0.

Verification
REQ-034 W=3,H=3, all taps 0x3FF, downstream always ready -> 9 outputs; masks 0x1B0,0x1F8,0x0D8,0x1B6,0x1FF,0x0DB,0x036,0x03F,0x01B; zeroed taps =0; o_last on 9th; o_done one cycle after 9th transfer.
REQ-035 W=1,H=1 -> one output, o_tap_mask=0x010, only center tap nonzero, o_last=1.
REQ-036 W=4,H=2, continuous valid/ready -> 8 outputs in 8 consecutive cycles, no bubbles.
REQ-037 i_win_ready low 5 cycles with o_win_valid=1 -> output fields stable, o_win_ready=0, no window lost or duplicated.
REQ-038 i_rst_n low 1 cycle after 4 of 9 windows -> o_win_valid=0, o_busy=0; new start yields first mask 0x1B0.
REQ-039 W=0 start -> no o_win_ready, o_done one pulse; i_start during RUN leaves counters unchanged.

Source files
------------

// File: rtl/pad_window_ctrl.sv
// Border-padding controller for a streamed 3x3 window: zeroes the taps that fall outside
// the frame and passes masked windows downstream through a one-deep valid/ready stage.
module pad_window_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DIM_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DIM_W-1:0]      i_cfg_width,
    input  logic [DIM_W-1:0]      i_cfg_height,
    input  logic                  i_win_valid,
    output logic                  o_win_ready,
    input  logic [9*DATA_W-1:0]   i_win_data,
    output logic                  o_win_valid,
    input  logic                  i_win_ready,
    output logic [9*DATA_W-1:0]   o_win_data,
    output logic [8:0]            o_tap_mask,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [DIM_W-1:0]     width_q, width_d;
    logic [DIM_W-1:0]     height_q, height_d;
    logic [DIM_W-1:0]     row_q, row_d;
    logic [DIM_W-1:0]     col_q, col_d;
    logic                 win_valid_q, win_valid_d;
    logic [9*DATA_W-1:0]  win_data_q, win_data_d;
    logic [8:0]           tap_mask_q, tap_mask_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;

    logic                 win_ready;
    logic                 accept;
    logic                 out_xfer;
    logic                 row_first, row_last, col_first, col_last;
    logic [8:0]           tap_keep;
    logic [9*DATA_W-1:0]  masked_data;

    always_comb begin
        win_ready = (state_q == StRun) && (!win_valid_q || i_win_ready);
        accept    = i_win_valid && win_ready;
        out_xfer  = win_valid_q && i_win_ready;
        row_first = (row_q == '0);
        row_last  = (row_q == height_q - DIM_W'(1));
        col_first = (col_q == '0);
        col_last  = (col_q == width_q - DIM_W'(1));
    end

    // A dimension of 1 makes first and last coincide, so both borders get zeroed.
    always_comb begin
        tap_keep = '1;
        for (int k = 0; k < 9; k++) begin
            if ((k < 3 && row_first) || (k >= 6 && row_last) ||
                (k % 3 == 0 && col_first) || (k % 3 == 2 && col_last)) begin
                tap_keep[k] = 1'b0;
            end
        end
    end

    always_comb begin
        masked_data = '0;
        for (int k = 0; k < 9; k++) begin
            if (tap_keep[k]) begin
                masked_data[DATA_W*k +: DATA_W] = i_win_data[DATA_W*k +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        tap_mask_d  = tap_mask_q;
        last_d      = last_q;
        done_d      = 1'b0;

        if (out_xfer) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    width_d  = i_cfg_width;
                    height_d = i_cfg_height;
                    row_d    = '0;
                    col_d    = '0;
                    if (i_cfg_width == '0 || i_cfg_height == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    win_valid_d = 1'b1;
                    win_data_d  = masked_data;
                    tap_mask_d  = tap_keep;
                    last_d      = row_last && col_last;
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                    if (row_last && col_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Wait for the final window to leave before signalling completion.
                if (!win_valid_q || out_xfer) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            width_q     <= '0;
            height_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            tap_mask_q  <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            tap_mask_q  <= tap_mask_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign o_win_ready = win_ready;
    assign o_win_valid = win_valid_q;
    assign o_win_data  = win_data_q;
    assign o_tap_mask  = tap_mask_q;
    assign o_last      = last_q;
    assign o_busy      = (state_q != StIdle);
    assign o_done      = done_q;

endmodule

// File: tb/tb_pad_window_ctrl.sv
// Bench for pad_window_ctrl: directed frames with random data and handshakes, checked
// against a frame-level model that derives each window's mask from its raster position.
module tb_pad_window_ctrl;

    localparam int DATA_W = 10;
    localparam int DIM_W  = 8;
    localparam int WD     = 9 * DATA_W;

    localparam logic [8:0] MASKS33 [9] = '{9'h1B0, 9'h1F8, 9'h0D8, 9'h1B6, 9'h1FF,
                                           9'h0DB, 9'h036, 9'h03F, 9'h01B};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [DIM_W-1:0]  cfg_w_i = '0;
    logic [DIM_W-1:0]  cfg_h_i = '0;
    logic              win_valid_i = 1'b0;
    logic              win_ready_o;
    logic [WD-1:0]     win_data_i = '0;
    logic              win_valid_o;
    logic              win_ready_i = 1'b0;
    logic [WD-1:0]     win_data_o;
    logic [8:0]        tap_mask_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;

    pad_window_ctrl #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start_i),
        .i_cfg_width  (cfg_w_i),
        .i_cfg_height (cfg_h_i),
        .i_win_valid  (win_valid_i),
        .o_win_ready  (win_ready_o),
        .i_win_data   (win_data_i),
        .o_win_valid  (win_valid_o),
        .i_win_ready  (win_ready_i),
        .o_win_data   (win_data_o),
        .o_tap_mask   (tap_mask_o),
        .o_last       (last_o),
        .o_busy       (busy_o),
        .o_done       (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level model
    bit          m_run, m_dst, m_pulse, m_pend;
    int          m_w, m_h, m_acc;
    logic [WD-1:0] m_data;
    logic [8:0]  m_mask;
    logic        m_last;
    int          n_xfer;
    logic [8:0]  seen [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_mask(input int idx, input int w, input int h);
        int row, col, r, c;
        logic [8:0] m;
        row = idx / w;
        col = idx % w;
        for (int k = 0; k < 9; k++) begin
            r = k / 3;
            c = k % 3;
            m[k] = !((r == 0 && row == 0) || (r == 2 && row == h - 1) ||
                     (c == 0 && col == 0) || (c == 2 && col == w - 1));
        end
        return m;
    endfunction

    function automatic logic [WD-1:0] apply_mask(input logic [WD-1:0] d, input logic [8:0] m);
        logic [WD-1:0] o;
        o = '0;
        for (int k = 0; k < 9; k++) begin
            if (m[k]) o[k*DATA_W +: DATA_W] = d[k*DATA_W +: DATA_W];
        end
        return o;
    endfunction

    function automatic logic [WD-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WD-1:0];
    endfunction

    task automatic step(input logic v, input logic [WD-1:0] d, input logic rdy, input logic st);
        bit acc, xfer, old_run, old_dst, old_pend;
        logic [8:0] obs_mask;
        @(negedge clk);
        win_valid_i = v;
        win_data_i  = d;
        win_ready_i = rdy;
        start_i     = st;
        #1;
        chk("ready", win_ready_o, m_run && (!m_pend || rdy));
        chk("valid", win_valid_o, m_pend);
        chk("busy", busy_o, m_run || m_dst);
        chk("done", done_o, m_pulse);
        if (m_pend) begin
            chk("data", win_data_o, m_data);
            chk("mask", tap_mask_o, m_mask);
            chk("last", last_o, m_last);
        end
        obs_mask = tap_mask_o;
        acc  = v && m_run && (!m_pend || rdy);
        xfer = m_pend && rdy;
        @(posedge clk);
        old_run  = m_run;
        old_dst  = m_dst;
        old_pend = m_pend;
        m_pulse  = 0;
        if (old_dst && (!old_pend || xfer)) begin
            m_dst   = 0;
            m_pulse = 1;
        end
        if (xfer) begin
            m_pend = 0;
            n_xfer++;
            seen.push_back(obs_mask);
        end
        if (acc) begin
            m_mask = exp_mask(m_acc, m_w, m_h);
            m_data = apply_mask(d, m_mask);
            m_last = (m_acc == m_w * m_h - 1);
            m_pend = 1;
            m_acc++;
            if (m_acc == m_w * m_h) begin
                m_run = 0;
                m_dst = 1;
            end
        end
        if (st && !old_run && !old_dst) begin
            m_w   = int'(cfg_w_i);
            m_h   = int'(cfg_h_i);
            m_acc = 0;
            if (m_w == 0 || m_h == 0) m_dst = 1;
            else m_run = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        start_i     = 1'b0;
        win_valid_i = 1'b0;
        win_ready_i = 1'b0;
        @(posedge clk);
        m_run = 0; m_dst = 0; m_pulse = 0; m_pend = 0; m_acc = 0;
        #1;
        chk("rst_valid", win_valid_o, 0);
        chk("rst_data", win_data_o, 0);
        chk("rst_mask", tap_mask_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", win_ready_o, 0);
        chk("rst_done", done_o, 0);
        rst_n = 1'b1;
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_w_i = DIM_W'(w);
        cfg_h_i = DIM_W'(h);
        seen.delete();
        n_xfer = 0;
        step(1'b0, '0, 1'b1, 1'b1);
    endtask

    // Runs until the model is idle, then one more cycle to observe the done pulse.
    task automatic finish_frame(input int pv, input int pr);
        int n;
        n = 0;
        while ((m_run || m_dst) && n < 4000) begin
            step($urandom_range(0, 99) < pv, rnd_data(), $urandom_range(0, 99) < pr, 1'b0);
            n++;
        end
        if (m_run || m_dst) chk("frame_timeout", n, 0);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [WD-1:0] ones;
        ones = '1;
        do_reset();

        // 3x3 all-ones, continuous
        start_frame(3, 3);
        for (int i = 0; i < 9; i++) step(1'b1, ones, 1'b1, 1'b0);
        finish_frame(100, 100);
        chk("m33_count", seen.size(), 9);
        for (int i = 0; i < 9 && i < seen.size(); i++) chk("m33_mask", seen[i], MASKS33[i]);

        // 1x1
        start_frame(1, 1);
        step(1'b1, ones, 1'b1, 1'b0);
        finish_frame(100, 100);
        chk("m11_count", seen.size(), 1);
        if (seen.size() > 0) chk("m11_mask", seen[0], 9'h010);

        // 4x2 with no bubbles: ready is checked every cycle
        start_frame(4, 2);
        for (int i = 0; i < 8; i++) step(1'b1, rnd_data(), 1'b1, 1'b0);
        chk("m42_xfers_in_8", n_xfer, 7);
        finish_frame(100, 100);
        chk("m42_count", n_xfer, 8);

        // Downstream stall for 5 cycles
        start_frame(3, 3);
        step(1'b1, rnd_data(), 1'b1, 1'b0);
        step(1'b1, rnd_data(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, rnd_data(), 1'b0, 1'b0);
        finish_frame(70, 60);
        chk("stall_count", n_xfer, 9);

        // Reset mid-frame, then a fresh frame starts at row 0, col 0
        start_frame(3, 3);
        for (int i = 0; i < 4; i++) step(1'b1, rnd_data(), 1'b1, 1'b0);
        do_reset();
        start_frame(3, 3);
        finish_frame(80, 80);
        chk("rst_restart_count", seen.size(), 9);
        if (seen.size() > 0) chk("rst_first_mask", seen[0], 9'h1B0);

        // Zero width
        start_frame(0, 3);
        finish_frame(100, 100);
        chk("w0_count", n_xfer, 0);

        // Start during RUN is ignored
        start_frame(2, 2);
        step(1'b1, rnd_data(), 1'b1, 1'b0);
        cfg_w_i = 8'd5;
        cfg_h_i = 8'd5;
        step(1'b1, rnd_data(), 1'b1, 1'b1);
        finish_frame(80, 80);
        chk("run_start_count", n_xfer, 4);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            int w, h;
            w = $urandom_range(0, 5);
            h = $urandom_range(0, 5);
            start_frame(w, h);
            finish_frame($urandom_range(40, 100), $urandom_range(40, 100));
            chk("rand_count", n_xfer, w * h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
